// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register with EX-stage operand forwarding and load-use
//   hazard detection. Feeds the 16-bit ALU (a, b, cin, less, op) and
//   the memory stage (store data, controls, destination register).
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   i_stall, i_flush         hold / bubble the ID/EX register (flush wins)
//   i_id_*                   decoded instruction fields from ID
//   i_exmem_*, i_memwb_*     downstream write-back info used for forwarding
//   o_alu_a, o_alu_b         forwarded ALU operands
//   o_alu_op, o_alu_cin      registered op code / subtract flag
//   o_alu_less               tied 0 (SLT is built downstream from set)
//   o_ex_valid               EX slot holds a real instruction
//   o_ex_store_data          forwarded rt value for stores
//   o_ex_rd                  registered destination register
//   o_ex_reg_write .. o_ex_mem_to_reg  controls gated by o_ex_valid
//   o_load_use_hazard        combinational; ID and IF hold this cycle

module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic [DATA_W-1:0] i_id_rs_data,
  input  logic [DATA_W-1:0] i_id_rt_data,
  input  logic [DATA_W-1:0] i_id_imm,
  input  logic [2:0]        i_id_alu_op,
  input  logic              i_id_alu_src,
  input  logic              i_id_sub,
  input  logic              i_id_reg_write,
  input  logic              i_id_mem_read,
  input  logic              i_id_mem_write,
  input  logic              i_id_mem_to_reg,
  input  logic              i_exmem_reg_write,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [2:0]        o_alu_op,
  output logic              o_alu_cin,
  output logic              o_alu_less,
  output logic              o_ex_valid,
  output logic [DATA_W-1:0] o_ex_store_data,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic              o_ex_reg_write,
  output logic              o_ex_mem_read,
  output logic              o_ex_mem_write,
  output logic              o_ex_mem_to_reg,
  output logic              o_load_use_hazard
);

  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [2:0]        r_alu_op;
  logic              r_alu_src;
  logic              r_sub;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  logic              w_load_use;
  logic              w_rs_hit;
  logic              w_rt_hit;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load in EX whose destination is read by the instruction in ID. The
  // loaded value only exists from MEM/WB onward, so one bubble is needed.
  // A flush kills the ID instruction anyway, so no hold is requested then.
  assign w_rs_hit   = (r_rd == i_id_rs);
  assign w_rt_hit   = (r_rd == i_id_rt);
  assign w_load_use = ~i_flush & r_valid & r_mem_read & i_id_valid &
                      (r_rd != '0) & (w_rs_hit | w_rt_hit);

  // A bubble clears every field, not just valid, so a squashed
  // instruction leaves no stale data behind in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_sub        <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (i_flush || (!i_stall && w_load_use)) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_op     <= '0;
      r_alu_src    <= 1'b0;
      r_sub        <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!i_stall) begin
      r_valid      <= i_id_valid;
      r_rs         <= i_id_rs;
      r_rt         <= i_id_rt;
      r_rd         <= i_id_rd;
      r_rs_data    <= i_id_rs_data;
      r_rt_data    <= i_id_rt_data;
      r_imm        <= i_id_imm;
      r_alu_op     <= i_id_alu_op;
      r_alu_src    <= i_id_alu_src;
      r_sub        <= i_id_sub;
      r_reg_write  <= i_id_reg_write;
      r_mem_read   <= i_id_mem_read;
      r_mem_write  <= i_id_mem_write;
      r_mem_to_reg <= i_id_mem_to_reg;
    end
  end

  // EX/MEM is the younger result, so it takes priority over MEM/WB.
  // Register 0 never forwards.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == r_rs))
      w_fwd_rs = i_exmem_result;
    else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == r_rs))
      w_fwd_rs = i_memwb_result;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == r_rt))
      w_fwd_rt = i_exmem_result;
    else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == r_rt))
      w_fwd_rt = i_memwb_result;
  end

  assign o_alu_a           = w_fwd_rs;
  assign o_alu_b           = r_alu_src ? r_imm : w_fwd_rt;
  assign o_ex_store_data   = w_fwd_rt;
  assign o_alu_op          = r_alu_op;
  assign o_alu_cin         = r_sub;
  assign o_alu_less        = 1'b0;
  assign o_ex_valid        = r_valid;
  assign o_ex_rd           = r_rd;
  assign o_ex_reg_write    = r_valid & r_reg_write;
  assign o_ex_mem_read     = r_valid & r_mem_read;
  assign o_ex_mem_write    = r_valid & r_mem_write;
  assign o_ex_mem_to_reg   = r_valid & r_mem_to_reg;
  assign o_load_use_hazard = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: a table of one-cycle vectors (ID fields,
// forwarding inputs, stall/flush, expected hazard before the edge and
// expected EX outputs after it), plus hand-written reset sequences.

module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_op;
  logic        id_alu_src, id_sub;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_result;
  logic [15:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_op, ex_rd;
  logic        alu_cin, alu_less, ex_valid;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        load_use_hazard;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_id_valid        (id_valid),
    .i_id_rs           (id_rs),
    .i_id_rt           (id_rt),
    .i_id_rd           (id_rd),
    .i_id_rs_data      (id_rs_data),
    .i_id_rt_data      (id_rt_data),
    .i_id_imm          (id_imm),
    .i_id_alu_op       (id_alu_op),
    .i_id_alu_src      (id_alu_src),
    .i_id_sub          (id_sub),
    .i_id_reg_write    (id_reg_write),
    .i_id_mem_read     (id_mem_read),
    .i_id_mem_write    (id_mem_write),
    .i_id_mem_to_reg   (id_mem_to_reg),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_alu_a           (alu_a),
    .o_alu_b           (alu_b),
    .o_alu_op          (alu_op),
    .o_alu_cin         (alu_cin),
    .o_alu_less        (alu_less),
    .o_ex_valid        (ex_valid),
    .o_ex_store_data   (ex_store_data),
    .o_ex_rd           (ex_rd),
    .o_ex_reg_write    (ex_reg_write),
    .o_ex_mem_read     (ex_mem_read),
    .o_ex_mem_write    (ex_mem_write),
    .o_ex_mem_to_reg   (ex_mem_to_reg),
    .o_load_use_hazard (load_use_hazard)
  );

  typedef struct {
    logic        stall, flush, id_valid;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rs_data, rt_data, imm;
    logic [2:0]  op;
    logic        alu_src, sub, rw, mr, mw, m2r;
    logic        exw;
    logic [2:0]  exrd;
    logic [15:0] exres;
    logic        wbw;
    logic [2:0]  wbrd;
    logic [15:0] wbres;
    logic        e_hz;     // hazard before the edge
    logic        e_valid;  // outputs after the edge
    logic [15:0] e_a, e_b, e_sd;
    logic [2:0]  e_op, e_rd;
    logic        e_cin;
    logic [3:0]  e_ctl;    // {reg_write, mem_read, mem_write, mem_to_reg}
  } vec_t;

  localparam int NV = 19;
  vec_t tv [NV];
  vec_t exp_q [$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s (step %0d): got %h expected %h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v);
    stall           = v.stall;
    flush           = v.flush;
    id_valid        = v.id_valid;
    id_rs           = v.rs;
    id_rt           = v.rt;
    id_rd           = v.rd;
    id_rs_data      = v.rs_data;
    id_rt_data      = v.rt_data;
    id_imm          = v.imm;
    id_alu_op       = v.op;
    id_alu_src      = v.alu_src;
    id_sub          = v.sub;
    id_reg_write    = v.rw;
    id_mem_read     = v.mr;
    id_mem_write    = v.mw;
    id_mem_to_reg   = v.m2r;
    exmem_reg_write = v.exw;
    exmem_rd        = v.exrd;
    exmem_result    = v.exres;
    memwb_reg_write = v.wbw;
    memwb_rd        = v.wbrd;
    memwb_result    = v.wbres;
  endtask

  task automatic check_ex(input vec_t e, input int idx);
    check("ex_valid",   idx, {15'd0, ex_valid}, {15'd0, e.e_valid});
    check("alu_a",      idx, alu_a, e.e_a);
    check("alu_b",      idx, alu_b, e.e_b);
    check("store_data", idx, ex_store_data, e.e_sd);
    check("alu_op",     idx, {13'd0, alu_op}, {13'd0, e.e_op});
    check("ex_rd",      idx, {13'd0, ex_rd}, {13'd0, e.e_rd});
    check("alu_cin",    idx, {15'd0, alu_cin}, {15'd0, e.e_cin});
    check("controls",   idx,
          {12'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {12'd0, e.e_ctl});
    check("alu_less",   idx, {15'd0, alu_less}, 16'd0);
  endtask

  initial begin
    vec_t cur;

    // v0: plain R-type capture, no forwarding
    tv[0] = blank();
    tv[0].id_valid = 1; tv[0].rs = 1; tv[0].rt = 2; tv[0].rd = 4;
    tv[0].rs_data = 16'h0011; tv[0].rt_data = 16'h0022; tv[0].imm = 16'h0033;
    tv[0].op = 3'd2; tv[0].rw = 1;
    tv[0].e_valid = 1; tv[0].e_a = 16'h0011; tv[0].e_b = 16'h0022; tv[0].e_sd = 16'h0022;
    tv[0].e_op = 3'd2; tv[0].e_rd = 3'd4; tv[0].e_ctl = 4'b1000;
    // v1: rs=2 matched by both EX/MEM and MEM/WB; EX/MEM wins
    tv[1] = blank();
    tv[1].id_valid = 1; tv[1].rs = 2; tv[1].rt = 0; tv[1].rd = 5;
    tv[1].rs_data = 16'h0AAA; tv[1].rt_data = 16'h0BBB; tv[1].op = 3'd1; tv[1].rw = 1;
    tv[1].exw = 1; tv[1].exrd = 2; tv[1].exres = 16'h1111;
    tv[1].wbw = 1; tv[1].wbrd = 2; tv[1].wbres = 16'h2222;
    tv[1].e_valid = 1; tv[1].e_a = 16'h1111; tv[1].e_b = 16'h0BBB; tv[1].e_sd = 16'h0BBB;
    tv[1].e_op = 3'd1; tv[1].e_rd = 3'd5; tv[1].e_ctl = 4'b1000;
    // v2: stall holds v1 while ID changes; EX/MEM write dropped -> MEM/WB
    tv[2] = tv[1];
    tv[2].stall = 1; tv[2].rs = 7; tv[2].rs_data = 16'h7777; tv[2].rd = 6;
    tv[2].exw = 0;
    tv[2].e_a = 16'h2222;
    // v3: EX/MEM targets r0 (never forwards); rt forwarded from MEM/WB
    tv[3] = blank();
    tv[3].id_valid = 1; tv[3].rs = 0; tv[3].rt = 3; tv[3].rd = 1;
    tv[3].rt_data = 16'h0303; tv[3].op = 3'd4; tv[3].sub = 1; tv[3].mw = 1;
    tv[3].exw = 1; tv[3].exrd = 0; tv[3].exres = 16'hFFFF;
    tv[3].wbw = 1; tv[3].wbrd = 3; tv[3].wbres = 16'h3333;
    tv[3].e_valid = 1; tv[3].e_a = 16'h0000; tv[3].e_b = 16'h3333; tv[3].e_sd = 16'h3333;
    tv[3].e_op = 3'd4; tv[3].e_rd = 3'd1; tv[3].e_cin = 1; tv[3].e_ctl = 4'b0010;
    // v4: immediate B operand, store data still rt, subtract
    tv[4] = blank();
    tv[4].id_valid = 1; tv[4].rs = 1; tv[4].rt = 2; tv[4].rd = 3;
    tv[4].rs_data = 16'h1234; tv[4].rt_data = 16'h0005; tv[4].imm = 16'hFFF8;
    tv[4].alu_src = 1; tv[4].sub = 1; tv[4].op = 3'd6; tv[4].rw = 1;
    tv[4].e_valid = 1; tv[4].e_a = 16'h1234; tv[4].e_b = 16'hFFF8; tv[4].e_sd = 16'h0005;
    tv[4].e_op = 3'd6; tv[4].e_rd = 3'd3; tv[4].e_cin = 1; tv[4].e_ctl = 4'b1000;
    // v5: load into r3
    tv[5] = blank();
    tv[5].id_valid = 1; tv[5].rs = 1; tv[5].rt = 0; tv[5].rd = 3;
    tv[5].rs_data = 16'h0100; tv[5].imm = 16'h0004; tv[5].alu_src = 1;
    tv[5].rw = 1; tv[5].mr = 1; tv[5].m2r = 1;
    tv[5].e_valid = 1; tv[5].e_a = 16'h0100; tv[5].e_b = 16'h0004; tv[5].e_sd = 16'h0000;
    tv[5].e_rd = 3'd3; tv[5].e_ctl = 4'b1101;
    // v6: ID reads r3 -> hazard, bubble enters EX
    tv[6] = blank();
    tv[6].id_valid = 1; tv[6].rs = 3; tv[6].rt = 1; tv[6].rd = 6;
    tv[6].rs_data = 16'h00AA; tv[6].rt_data = 16'h0011; tv[6].op = 3'd2; tv[6].rw = 1;
    tv[6].e_hz = 1;
    // v7: held ID instruction enters EX, r3 arrives via MEM/WB
    tv[7] = tv[6];
    tv[7].wbw = 1; tv[7].wbrd = 3; tv[7].wbres = 16'hBEEF;
    tv[7].e_hz = 0;
    tv[7].e_valid = 1; tv[7].e_a = 16'hBEEF; tv[7].e_b = 16'h0011; tv[7].e_sd = 16'h0011;
    tv[7].e_op = 3'd2; tv[7].e_rd = 3'd6; tv[7].e_ctl = 4'b1000;
    // v8: stall and flush together -> bubble
    tv[8] = blank();
    tv[8].stall = 1; tv[8].flush = 1;
    tv[8].id_valid = 1; tv[8].rs = 1; tv[8].rd = 2; tv[8].rs_data = 16'h5A5A;
    tv[8].mr = 1; tv[8].rw = 1; tv[8].op = 3'd7;
    // v9: load into r2
    tv[9] = blank();
    tv[9].id_valid = 1; tv[9].rd = 2; tv[9].rw = 1; tv[9].mr = 1; tv[9].m2r = 1;
    tv[9].e_valid = 1; tv[9].e_rd = 3'd2; tv[9].e_ctl = 4'b1101;
    // v10: dependent instruction with flush -> no hazard, bubble
    tv[10] = blank();
    tv[10].flush = 1; tv[10].id_valid = 1; tv[10].rs = 2; tv[10].rd = 4;
    tv[10].rs_data = 16'h1212; tv[10].rw = 1; tv[10].op = 3'd3;
    // v11: store to capture, then three stall cycles
    tv[11] = blank();
    tv[11].id_valid = 1; tv[11].rs = 4; tv[11].rt = 5; tv[11].rd = 7;
    tv[11].rs_data = 16'h4444; tv[11].rt_data = 16'h5555; tv[11].op = 3'd5;
    tv[11].mw = 1; tv[11].sub = 1;
    tv[11].e_valid = 1; tv[11].e_a = 16'h4444; tv[11].e_b = 16'h5555; tv[11].e_sd = 16'h5555;
    tv[11].e_op = 3'd5; tv[11].e_rd = 3'd7; tv[11].e_cin = 1; tv[11].e_ctl = 4'b0010;
    for (int k = 12; k <= 14; k++) begin
      tv[k] = tv[11];
      tv[k].stall = 1; tv[k].rs = 1; tv[k].rs_data = 16'h9999; tv[k].rd = 3;
      tv[k].rw = 1; tv[k].mw = 0; tv[k].op = 3'd1;
    end
    // v15: load into r5
    tv[15] = blank();
    tv[15].id_valid = 1; tv[15].rd = 5; tv[15].rw = 1; tv[15].mr = 1; tv[15].m2r = 1;
    tv[15].e_valid = 1; tv[15].e_rd = 3'd5; tv[15].e_ctl = 4'b1101;
    // v16: rt matches but ID not valid -> no hazard; invalid captured
    tv[16] = blank();
    tv[16].id_valid = 0; tv[16].rs = 1; tv[16].rt = 5; tv[16].rd = 0;
    tv[16].rs_data = 16'h0001; tv[16].rt_data = 16'h0002; tv[16].rw = 1;
    tv[16].e_a = 16'h0001; tv[16].e_b = 16'h0002; tv[16].e_sd = 16'h0002;
    // v17: load into r5 again
    tv[17] = tv[15];
    // v18: valid reader of r5 through rt -> hazard, bubble
    tv[18] = blank();
    tv[18].id_valid = 1; tv[18].rs = 0; tv[18].rt = 5; tv[18].rd = 1;
    tv[18].rt_data = 16'h0002; tv[18].op = 3'd3; tv[18].rw = 1;
    tv[18].e_hz = 1;

    // Reset state
    drive(blank());
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ex_valid", -1, {15'd0, ex_valid}, 16'd0);
    check("rst controls", -1,
          {12'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 16'd0);
    check("rst alu_op", -1, {13'd0, alu_op}, 16'd0);
    check("rst alu_cin", -1, {15'd0, alu_cin}, 16'd0);
    check("rst alu_a", -1, alu_a, 16'd0);
    check("rst hazard", -1, {15'd0, load_use_hazard}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst ex_valid", -1, {15'd0, ex_valid}, 16'd0);

    // Table run
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      exp_q.push_back(tv[i]);
      #1;
      check("load_use_hazard", i, {15'd0, load_use_hazard}, {15'd0, tv[i].e_hz});
      @(posedge clk);
      #1;
      cur = exp_q.pop_front();
      check_ex(cur, i);
    end

    // Reset in the middle of a cycle discards the EX instruction
    @(negedge clk);
    cur = tv[5];
    drive(cur);
    @(posedge clk);
    #1;
    check("pre-reset ex_valid", 100, {15'd0, ex_valid}, 16'd1);
    drive(blank());
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-rst ex_valid", 100, {15'd0, ex_valid}, 16'd0);
    check("mid-rst controls", 100,
          {12'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 16'd0);
    check("mid-rst ex_rd", 100, {13'd0, ex_rd}, 16'd0);
    check("mid-rst alu_b", 100, alu_b, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = tv[0];
    drive(cur);
    #1;
    check("release ex_valid", 101, {15'd0, ex_valid}, 16'd0);
    @(posedge clk);
    #1;
    check_ex(cur, 101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
